// File: rtl/uart_rx_nmea.sv
// uart_rx_nmea: 8N1 UART receiver (LSB first) feeding the NMEA sentence parser.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   i_Rx_Serial  asynchronous serial input, idles high
//   uart_data    last good byte; held until the next good byte
//   uart_valid   one-cycle pulse, uart_data is new in the same cycle
//   o_frame_err  one-cycle pulse when the stop bit is sampled low
//   o_rx_busy    high whenever the receiver is not idle
//
// Parameters:
//   CLKS_PER_BIT clk cycles per bit (>= 4)
//   SYNC_STAGES  metastability flops on i_Rx_Serial (>= 2)
module uart_rx_nmea #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_Rx_Serial,
    output logic [7:0] uart_data,
    output logic       uart_valid,
    output logic       o_frame_err,
    output logic       o_rx_busy
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    // START samples when the counter reaches H-1, i.e. H cycles after the edge is seen.
    localparam logic [CntW-1:0] HalfLast = CntW'((CLKS_PER_BIT - 1) / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;

    logic [SYNC_STAGES-1:0] sync_q;
    // Tracks which sync stages hold a real line sample rather than a reset value.
    logic [SYNC_STAGES-1:0] sync_vld_q;
    logic                   prev_q;
    logic                   rx_s;
    logic                   rx_real;
    logic                   fall;

    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign rx_real = sync_vld_q[SYNC_STAGES-1];
    // prev_q only ever holds a genuinely observed high, so a line that is already
    // low when reset is released (flops preset to 1) is not mistaken for a start edge.
    assign fall    = rx_real & ~rx_s & prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q     <= '1;
            sync_vld_q <= '0;
            prev_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], i_Rx_Serial};
            sync_vld_q <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
            prev_q     <= rx_s & rx_real;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // A high line at mid start bit means the low pulse was a glitch.
                    state_d = rx_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = rx_s;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        // Leaving early (mid stop bit) lets a following start bit be caught.
                        state_d = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StWaitHigh;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitHigh: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign uart_data   = data_q;
    assign uart_valid  = valid_q;
    assign o_frame_err = ferr_q;
    assign o_rx_busy   = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_nmea.sv
module tb_uart_rx_nmea;

    localparam int N    = 8;
    localparam int H    = (N - 1) / 2;
    localparam int SYNC = 2;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] uart_data;
    logic       uart_valid;
    logic       o_frame_err;
    logic       o_rx_busy;

    uart_rx_nmea #(
        .CLKS_PER_BIT(N),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_Rx_Serial(rx),
        .uart_data  (uart_data),
        .uart_valid (uart_valid),
        .o_frame_err(o_frame_err),
        .o_rx_busy  (o_rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  valid_times[$];
    int  cyc = 0;
    int  n_valid = 0;
    int  tests = 0;
    int  fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops an expected event whenever the DUT pulses an output.
    always @(negedge clk) begin
        if (rst && (uart_valid || o_frame_err)) begin
            check("valid_err_exclusive", {31'd0, uart_valid & o_frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event: got valid=%b err=%b data=0x%0h, required none",
                         uart_valid, o_frame_err, uart_data);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("event_kind_err", {31'd0, o_frame_err}, {31'd0, e.is_err});
                check("event_data", {24'd0, uart_data}, {24'd0, e.data});
            end
            if (uart_valid) begin
                valid_times.push_back(cyc);
                n_valid++;
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        wait_cyc(N);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cyc(N);
        end
        rx = stop;
        wait_cyc(N);
    endtask

    task automatic send_good(input logic [7:0] b);
        exp_q.push_back('{is_err: 1'b0, data: b});
        send_byte(b, 1'b1);
    endtask

    logic [7:0] gpgga [7];
    int         nv0;

    initial begin
        gpgga = '{8'h24, 8'h47, 8'h50, 8'h47, 8'h47, 8'h41, 8'h2C};
        rst = 1'b0;
        rx  = 1'b1;
        wait_cyc(3);
        check("reset_data", {24'd0, uart_data}, 32'h0);
        check("reset_valid", {31'd0, uart_valid}, 32'd0);
        check("reset_ferr", {31'd0, o_frame_err}, 32'd0);
        check("reset_busy", {31'd0, o_rx_busy}, 32'd0);
        rst = 1'b1;
        wait_cyc(5);

        // 1: single '$'
        send_good(8'h24);
        wait_cyc(10);
        check("t1_nvalid", n_valid, 32'd1);
        check("t1_data", {24'd0, uart_data}, 32'h24);
        check("t1_busy_low", {31'd0, o_rx_busy}, 32'd0);

        // 2: "$GPGGA," back to back
        valid_times.delete();
        for (int i = 0; i < 7; i++) send_good(gpgga[i]);
        wait_cyc(10);
        check("t2_count", valid_times.size(), 32'd7);
        for (int i = 1; i < valid_times.size(); i++)
            check("t2_spacing", valid_times[i] - valid_times[i-1], 32'd80);

        // 3: glitch of 2 cycles
        nv0 = n_valid;
        rx = 1'b0;
        wait_cyc(2);
        rx = 1'b1;
        wait_cyc(H + SYNC + 2);
        check("t3_idle_after_glitch", {31'd0, o_rx_busy}, 32'd0);
        check("t3_no_valid", n_valid, nv0);
        send_good(8'h31);
        wait_cyc(10);
        check("t3_data", {24'd0, uart_data}, 32'h31);

        // 4: framing error, data must stay at 0x31
        exp_q.push_back('{is_err: 1'b1, data: 8'h31});
        nv0 = n_valid;
        send_byte(8'h47, 1'b0);
        wait_cyc(20);
        check("t4_busy_while_low", {31'd0, o_rx_busy}, 32'd1);
        check("t4_no_valid", n_valid, nv0);
        check("t4_data_held", {24'd0, uart_data}, 32'h31);
        rx = 1'b1;
        wait_cyc(SYNC + 4);
        check("t4_idle_after_rise", {31'd0, o_rx_busy}, 32'd0);
        send_good(8'h50);
        wait_cyc(10);
        check("t4_next_data", {24'd0, uart_data}, 32'h50);

        // 5: reset during data bit 3 of 0x33
        rx = 1'b0;
        wait_cyc(N);
        for (int i = 0; i < 3; i++) begin
            rx = 1'(8'h33 >> i);
            wait_cyc(N);
        end
        rx = 1'(8'h33 >> 3);
        wait_cyc(N / 2);
        check("t5_busy_before_rst", {31'd0, o_rx_busy}, 32'd1);
        rst = 1'b0;
        #1;
        check("t5_rst_data", {24'd0, uart_data}, 32'h0);
        check("t5_rst_valid", {31'd0, uart_valid}, 32'd0);
        check("t5_rst_ferr", {31'd0, o_frame_err}, 32'd0);
        check("t5_rst_busy", {31'd0, o_rx_busy}, 32'd0);
        rx = 1'b1;
        wait_cyc(3);
        rst = 1'b1;
        wait_cyc(5);
        send_good(8'h4E);
        wait_cyc(10);
        check("t5_data", {24'd0, uart_data}, 32'h4E);

        // 6: line low through reset release
        rst = 1'b0;
        rx  = 1'b0;
        wait_cyc(3);
        rst = 1'b1;
        nv0 = n_valid;
        wait_cyc(50);
        check("t6_idle_while_low", {31'd0, o_rx_busy}, 32'd0);
        rx = 1'b1;
        wait_cyc(20);
        check("t6_no_valid", n_valid, nv0);
        send_good(8'h45);
        wait_cyc(10);
        check("t6_data", {24'd0, uart_data}, 32'h45);
        check("t6_one_valid", n_valid, nv0 + 1);

        check("all_events_seen", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
